// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: read ports,
// write ports, reservation/release controls and status.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 15,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]        srcA, srcB, dstE, dstM, rsvE_id, rsvM_id;
  logic [DATA_W-1:0]      valA, valB, valE, valM;
  logic                   weE, weM, rsvE_en, rsvM_en, relE_en, relM_en;
  logic                   busyA, busyB, err;
  logic [NREG*DATA_W-1:0] regs_flat;

  modport master (
    output srcA, srcB, dstE, dstM, valE, valM, weE, weM,
           rsvE_en, rsvM_en, rsvE_id, rsvM_id, relE_en, relM_en,
    input  valA, valB, busyA, busyB, err, regs_flat
  );

  modport slave (
    input  srcA, srcB, dstE, dstM, valE, valM, weE, weM,
           rsvE_en, rsvM_en, rsvE_id, rsvM_id, relE_en, relM_en,
    output valA, valB, busyA, busyB, err, regs_flat
  );
endinterface

// File: rtl/regfile_sb.sv
// Y86-64 register file: two combinational read ports, E/M write ports with
// optional bypass, and per-register pending-producer counters for hazard detection.
module regfile_sb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 15,
  parameter int unsigned ID_W   = 4,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CNT_W  = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave rf
);
  localparam logic [ID_W-1:0] RNONE = '1;
  localparam int unsigned     SW    = CNT_W + 2;

  logic [DATA_W-1:0] regs    [NREG];
  logic [CNT_W-1:0]  cnt     [NREG];
  logic [SW-1:0]     cnt_sum [NREG];
  logic [NREG-1:0]   cnt_bad;
  logic              err_q;

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (id != RNONE) && (32'(id) < NREG);
  endfunction

  function automatic logic hit(input logic en, input logic [ID_W-1:0] id,
                               input int unsigned i);
    return en && id_ok(id) && (32'(id) == i);
  endfunction

  // M has priority over E on the bypass path, matching write priority.
  always_comb begin
    rf.valA  = '0;
    rf.busyA = 1'b0;
    if (id_ok(rf.srcA)) begin
      rf.valA  = regs[rf.srcA];
      rf.busyA = |cnt[rf.srcA];
      if (BYPASS && rf.weM && (rf.dstM == rf.srcA))      rf.valA = rf.valM;
      else if (BYPASS && rf.weE && (rf.dstE == rf.srcA)) rf.valA = rf.valE;
    end
  end

  always_comb begin
    rf.valB  = '0;
    rf.busyB = 1'b0;
    if (id_ok(rf.srcB)) begin
      rf.valB  = regs[rf.srcB];
      rf.busyB = |cnt[rf.srcB];
      if (BYPASS && rf.weM && (rf.dstM == rf.srcB))      rf.valB = rf.valM;
      else if (BYPASS && rf.weE && (rf.dstE == rf.srcB)) rf.valB = rf.valE;
    end
  end

  // Net count computed two bits wider: the top bit flags a negative result,
  // the next bit flags a result above the counter's range.
  always_comb begin
    cnt_bad = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_sum[i] = {2'b00, cnt[i]}
                 + SW'(hit(rf.rsvE_en, rf.rsvE_id, i))
                 + SW'(hit(rf.rsvM_en, rf.rsvM_id, i))
                 - SW'(hit(rf.relE_en, rf.dstE, i))
                 - SW'(hit(rf.relM_en, rf.dstM, i));
      cnt_bad[i] = cnt_sum[i][SW-1] | cnt_sum[i][SW-2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (hit(rf.weM, rf.dstM, i))      regs[i] <= rf.valM;
        else if (hit(rf.weE, rf.dstE, i)) regs[i] <= rf.valE;
        if (!cnt_bad[i]) cnt[i] <= cnt_sum[i][CNT_W-1:0];
      end
      if (|cnt_bad) err_q <= 1'b1;
    end
  end

  assign rf.err = err_q;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign rf.regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end
endmodule
